muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Multi-cycle iterative multiply/divide unit in the execute stage. It replaces the single-cycle 64-bit product/quotient path that feeds the HI/LO registers. It accepts MULT/MULTU/DIV/DIVU operands from the forwarded ALU inputs and owns the HI/LO architectural state. Its Busy output tells the hazard/stall logic to freeze IF/ID and ID/EX until the result is written.

Parameters:
WIDTH, 32, operand width and HI/LO register width; the iteration count equals WIDTH.

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-low reset
Start  input  1  request a new operation; sampled only when the unit accepts (IDLE or DONE)
Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
OperandA  input  WIDTH  rs value (multiplicand or dividend)
OperandB  input  WIDTH  rt value (multiplier or divisor)
Flush  input  1  abort the in-flight operation (branch or jump squash)
WriteHi  input  1  MTHI write enable
WriteLo  input  1  MTLO write enable
WriteData  input  WIDTH  MTHI/MTLO data
Hi  output  WIDTH  HI register (product[63:32] or remainder)
Lo  output  WIDTH  LO register (product[31:0] or quotient)
Busy  output  1  operation in flight; the pipeline must stall MFHI/MFLO and new mul/div
Done  output  1  one-cycle pulse in the first cycle Hi/Lo show a new result
DivByZero  output  1  high with Done when the completed divide had OperandB == 0; otherwise 0

Behaviour:
- Reset is synchronous and active-low: on a Clk edge with Reset == 0, the unit goes to IDLE and Hi = 0, Lo = 0, Busy = 0, Done = 0, DivByZero = 0. Iteration registers are cleared.
- Priority at every edge: Reset > Flush > Start > WriteHi/WriteLo.
- States:
  - IDLE: Busy = 0.
  - MUL: Busy = 1.
  - DIV: Busy = 1.
  - FIX: Busy = 1.
  - DONE: Busy = 0, Done = 1.
- IDLE or DONE, Start = 1:
  - Latch the operand magnitudes. Signed ops use |x|; unsigned ops take the operand as-is.
  - Latch the result signs: product sign = signA ^ signB; quotient sign = signA ^ signB; remainder sign = signA.
  - Clear the counter.
  - Go to MUL (Op[1] = 0) or DIV (Op[1] = 1).
  - Divide with OperandB == 0 goes directly to FIX and sets the zero flag.
- MUL runs WIDTH cycles of shift-add on a 2*WIDTH accumulator, one multiplier bit per cycle. Go to FIX when counter == WIDTH-1.
- DIV runs WIDTH cycles of restoring division, one quotient bit per cycle: shift {rem, quo} left, trial-subtract the divisor, restore if the result is negative. Go to FIX when counter == WIDTH-1.
- FIX:
  - Apply two's-complement negation per the latched signs, with 2*WIDTH negation for products.
  - Write Hi/Lo at the exit edge, then go to DONE.
  - Divide by zero: Hi = OperandA as latched (original, unsigned view), Lo = all ones, DivByZero = 1.
- DONE lasts one cycle: Done = 1, then IDLE. A Start in DONE is accepted, so back-to-back operations are legal.
- Latency: Start sampled at edge E0 gives Done high in cycle E0 + WIDTH + 2 (34 for WIDTH = 32). Divide by zero gives Done at E0 + 2.
- Start while Busy = 1 is ignored; it is neither queued nor errored.
- Flush while Busy: next state is IDLE, Hi/Lo keep their pre-operation values, and there is no Done. Flush in IDLE or DONE cancels a simultaneous Start.
- WriteHi/WriteLo:
  - Take effect at the edge only in IDLE or DONE with Start = 0.
  - Are ignored while Busy or when Start = 1.
  - Both may be written in the same cycle.
- Overflow case: signed -2^(W-1) / -1 produces magnitude 2^(W-1) with no negation, giving Lo = 0x80000000 and Hi = 0. This wraps, with no trap.
- Hi/Lo change only at the FIX exit edge, on an MTHI/MTLO write, or on reset.

Test Plan:
- Reset low 2 cycles, then MULTU 0xFFFFFFFF * 0xFFFFFFFF -> Busy for 33 cycles; Done at cycle 34; Hi = 0xFFFFFFFE, Lo = 0x00000001.
- MULT -3 * 7 -> Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB. Then, back-to-back Start in DONE, MULT 0x80000000 * 0x80000000 -> Hi = 0x40000000, Lo = 0.
- DIV -7 / 2 -> Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF. DIVU 100 / 7 -> Lo = 14, Hi = 2. DIV 0x80000000 / 0xFFFFFFFF -> Lo = 0x80000000, Hi = 0.
- DIVU 5 / 0 -> Done at cycle 2 after Start, DivByZero = 1, Hi = 5, Lo = 0xFFFFFFFF. The next normal op completes with DivByZero = 0.
- Preload via WriteHi = 0x11, WriteLo = 0x22, then start DIVU 9 / 3:
  - Flush at cycle 10 -> Busy = 0 next cycle, no Done, Hi = 0x11, Lo = 0x22.
  - Start and WriteLo pulses during a separate busy op are ignored.
- Start MULT, drive Reset low at cycle 20 -> next edge Busy = 0, Hi = Lo = 0, Done never pulses.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// One multiplier or quotient bit per cycle, followed by a sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Flush,
  input  logic             WriteHi,
  input  logic             WriteLo,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t               state, nextState;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     bMag;
  logic                 negQuo, negRem, isDiv, zeroFlag;

  logic                 accept, launch, lastIter, signedOp, signA, signB, divZero;
  logic [WIDTH-1:0]     aMagIn, bMagIn;
  logic [WIDTH:0]       mulSum, shiftRem;
  logic [WIDTH-1:0]     trial;
  logic                 geq;
  logic [2*WIDTH-1:0]   divNext, prodFix;
  logic [WIDTH-1:0]     fixHi, fixLo;

  function automatic logic [WIDTH-1:0] absVal(input logic signed [WIDTH-1:0] x,
                                              input logic isSigned);
    return (isSigned && x < 0) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] applySign(input logic [WIDTH-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  function automatic logic [2*WIDTH-1:0] applySign2w(input logic [2*WIDTH-1:0] mag,
                                                    input logic neg);
    return neg ? -mag : mag;
  endfunction

  assign accept   = (state == IDLE) || (state == DONE);
  assign launch   = accept && Start && !Flush;
  assign lastIter = (count == CNT_W'(WIDTH-1));
  assign signedOp = !Op[0];
  assign signA    = signedOp && OperandA[WIDTH-1];
  assign signB    = signedOp && OperandB[WIDTH-1];
  assign divZero  = Op[1] && (OperandB == '0);
  assign aMagIn   = absVal(OperandA, signedOp);
  assign bMagIn   = absVal(OperandB, signedOp);

  // Shift-add step: low half holds the remaining multiplier bits
  assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? bMag : '0)};

  // Restoring-division step on {rem, quo}
  assign shiftRem = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign geq      = shiftRem >= {1'b0, bMag};
  assign trial    = shiftRem[WIDTH-1:0] - bMag;
  assign divNext  = geq ? {trial, acc[WIDTH-2:0], 1'b1}
                        : {shiftRem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  assign prodFix  = applySign2w(acc, negQuo);

  always_comb begin
    fixHi = prodFix[2*WIDTH-1:WIDTH];
    fixLo = prodFix[WIDTH-1:0];
    if (zeroFlag) begin
      fixHi = acc[2*WIDTH-1:WIDTH];
      fixLo = '1;
    end else if (isDiv) begin
      fixHi = applySign(acc[2*WIDTH-1:WIDTH], negRem);
      fixLo = applySign(acc[WIDTH-1:0], negQuo);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE: begin
        if (Flush || !Start) nextState = IDLE;
        else if (!Op[1])     nextState = MUL;
        else if (divZero)    nextState = FIX;
        else                 nextState = DIV;
      end
      MUL, DIV: begin
        if (Flush)         nextState = IDLE;
        else if (lastIter) nextState = FIX;
      end
      FIX:     nextState = Flush ? IDLE : DONE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    Busy      = 1'b0;
    Done      = 1'b0;
    DivByZero = 1'b0;
    case (state)
      MUL, DIV, FIX: Busy = 1'b1;
      DONE: begin
        Done      = 1'b1;
        DivByZero = zeroFlag;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      acc      <= '0;
      bMag     <= '0;
      count    <= '0;
      negQuo   <= 1'b0;
      negRem   <= 1'b0;
      isDiv    <= 1'b0;
      zeroFlag <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            // Divide by zero keeps the raw dividend for HI
            acc      <= divZero ? {OperandA, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, aMagIn};
            bMag     <= bMagIn;
            count    <= '0;
            negQuo   <= signA ^ signB;
            negRem   <= signA;
            isDiv    <= Op[1];
            zeroFlag <= divZero;
          end else if (!Flush && !Start) begin
            if (WriteHi) Hi <= WriteData;
            if (WriteLo) Lo <= WriteData;
          end
        end
        MUL: if (!Flush) begin
          acc   <= {mulSum, acc[WIDTH-1:1]};
          count <= count + CNT_W'(1);
        end
        DIV: if (!Flush) begin
          acc   <= divNext;
          count <= count + CNT_W'(1);
        end
        FIX: if (!Flush) begin
          Hi <= fixHi;
          Lo <= fixLo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit against a plain-arithmetic
// reference of MULT/MULTU/DIV/DIVU, plus flush, reset and MTHI/MTLO scenarios.
module tb_muldiv_unit;
  localparam int WIDTH = 32;

  logic              Clk = 1'b0;
  logic              Reset, Start, Flush, WriteHi, WriteLo;
  logic [1:0]        Op;
  logic [WIDTH-1:0]  OperandA, OperandB, WriteData, Hi, Lo;
  logic              Busy, Done, DivByZero;

  int checks = 0;
  int passes = 0;

  always #5 Clk = ~Clk;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB), .Flush(Flush),
    .WriteHi(WriteHi), .WriteLo(WriteLo), .WriteData(WriteData),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
  );

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Returns {divByZero, hi, lo}
  function automatic logic [64:0] refModel(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p, qv, rv;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: begin p = sa * sb; return {1'b0, p}; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          q = sa / sb; r = sa % sb;
          qv = q; rv = r;
          return {1'b0, rv[31:0], qv[31:0]};
        end
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    tick();
    Start = 1'b0; OperandA = $urandom; OperandB = $urandom;
  endtask

  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int pokeAt);
    logic [64:0] exp;
    int cyc, busyCyc, lat;
    exp = refModel(op, a, b);
    lat = (op[1] && b == 0) ? 2 : WIDTH + 2;
    cyc = 1;
    busyCyc = 0;
    startOp(op, a, b);
    while (!Done && cyc < 200) begin
      if (Busy) busyCyc++;
      if (cyc == pokeAt) begin
        Start = 1'b1; Op = ~op; WriteHi = 1'b1; WriteLo = 1'b1; WriteData = 32'hDEAD_BEEF;
      end
      tick();
      cyc++;
      Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
    end
    checkEq("latency", 64'(cyc), 64'(lat));
    checkEq("busyCycles", 64'(busyCyc), 64'(lat - 1));
    checkEq("hi", 64'(Hi), 64'(exp[63:32]));
    checkEq("lo", 64'(Lo), 64'(exp[31:0]));
    checkEq("divByZero", 64'(DivByZero), 64'(exp[64]));
  endtask

  task automatic watchNoDone(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (Done) seen++;
      tick();
    end
    checkEq(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Flush = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
    Op = 2'b00; OperandA = '0; OperandB = '0; WriteData = '0;
    repeat (2) tick();
    checkEq("rstHi", 64'(Hi), 64'd0);
    checkEq("rstLo", 64'(Lo), 64'd0);
    checkEq("rstBusy", 64'(Busy), 64'd0);
    checkEq("rstDone", 64'(Done), 64'd0);
    checkEq("rstDbz", 64'(DivByZero), 64'd0);
    Reset = 1'b1;
    tick();

    // Directed multiplies, the last one back-to-back from DONE
    runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    checkEq("multuHiConst", 64'(Hi), 64'hFFFF_FFFE);
    checkEq("multuLoConst", 64'(Lo), 64'h0000_0001);
    tick();
    checkEq("donePulse", 64'(Done), 64'd0);
    checkEq("hiHold", 64'(Hi), 64'hFFFF_FFFE);
    runOp(2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    checkEq("multLoConst", 64'(Lo), 64'hFFFF_FFEB);
    runOp(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    checkEq("multMinHiConst", 64'(Hi), 64'h4000_0000);
    tick();

    // Directed divides
    runOp(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    checkEq("divQuoConst", 64'(Lo), 64'hFFFF_FFFD);
    checkEq("divRemConst", 64'(Hi), 64'hFFFF_FFFF);
    runOp(2'b11, 32'd100, 32'd7, 0);
    checkEq("divuQuoConst", 64'(Lo), 64'd14);
    runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    checkEq("divOvfConst", 64'(Lo), 64'h8000_0000);
    runOp(2'b11, 32'd5, 32'd0, 0);
    checkEq("dbzHiConst", 64'(Hi), 64'd5);
    runOp(2'b11, 32'd20, 32'd6, 0);
    tick();

    // MTHI/MTLO preload, then flush mid-divide
    WriteHi = 1'b1; WriteData = 32'h11;
    tick();
    WriteHi = 1'b0; WriteLo = 1'b1; WriteData = 32'h22;
    tick();
    WriteLo = 1'b0;
    checkEq("preHi", 64'(Hi), 64'h11);
    checkEq("preLo", 64'(Lo), 64'h22);
    startOp(2'b11, 32'd9, 32'd3);
    repeat (9) tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    checkEq("flushBusy", 64'(Busy), 64'd0);
    checkEq("flushHi", 64'(Hi), 64'h11);
    checkEq("flushLo", 64'(Lo), 64'h22);
    watchNoDone("flushNoDone", 40);
    checkEq("flushLoKept", 64'(Lo), 64'h22);

    // Start and MTHI/MTLO while busy are ignored
    runOp(2'b11, 32'd9, 32'd3, 5);
    tick();

    // Reset in the middle of a multiply
    startOp(2'b00, $urandom, $urandom);
    repeat (19) tick();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    checkEq("midRstBusy", 64'(Busy), 64'd0);
    checkEq("midRstHi", 64'(Hi), 64'd0);
    checkEq("midRstLo", 64'(Lo), 64'd0);
    watchNoDone("midRstNoDone", 40);

    // Random operations, mixing idle gaps and back-to-back starts
    for (int i = 0; i < 40; i++) begin
      runOp(2'($urandom_range(0, 3)), pickOperand(), pickOperand(), 0);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
